// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: FSM states and load funct3 codes.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_WAIT   = 2'd1,
        WB_COMMIT = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions, waits for load data, and
// produces the registered register-file write, commit strobe and retire count.
module load_ext
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [63:0]     rdata_i,
    input  logic [2:0]      addr_lo_i,
    input  logic [2:0]      fun3_i,
    output logic [XLEN-1:0] data_o
);

    logic [63:0] shifted;
    logic [63:0] ext;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        ext     = '0;
        case (fun3_i)
            F3_LB:   ext = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   ext = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   ext = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   ext = shifted;
            F3_LBU:  ext = {56'd0, shifted[7:0]};
            F3_LHU:  ext = {48'd0, shifted[15:0]};
            F3_LWU:  ext = {32'd0, shifted[31:0]};
            default: ext = '0;
        endcase
        data_o = XLEN'(ext);
    end

endmodule

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            wben_i,
    input  logic            is_load_i,
    input  logic [2:0]      load_fun3_i,
    input  logic [2:0]      addr_lo_i,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic            mem_rvalid_i,
    input  logic [63:0]     mem_rdata_i,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_rdid_o,
    output logic            wb_wren_o,
    output logic [XLEN-1:0] pc_wb_o,
    output logic            commit_o,
    output logic [63:0]     commit_cnt_o
);

    wb_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rd_q, rd_d;
    logic            wben_q, wben_d;
    logic [2:0]      fun3_q, fun3_d;
    logic [2:0]      alo_q, alo_d;

    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rdid_q, wb_rdid_d;
    logic            wb_wren_q, wb_wren_d;
    logic [XLEN-1:0] pc_wb_q, pc_wb_d;
    logic            commit_q, commit_d;
    logic [63:0]     cnt_q, cnt_d;

    logic            transfer;
    logic [XLEN-1:0] ld_data;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata_i   (mem_rdata_i),
        .addr_lo_i (alo_q),
        .fun3_i    (fun3_q),
        .data_o    (ld_data)
    );

    assign in_ready_o = (state_q != WB_WAIT);
    assign transfer   = in_valid_i & in_ready_o;

    // Output registers are loaded on the edge that enters COMMIT, so they
    // hold steady through IDLE/WAIT while only the strobes drop.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        wben_d    = wben_q;
        fun3_d    = fun3_q;
        alo_d     = alo_q;
        wb_data_d = wb_data_q;
        wb_rdid_d = wb_rdid_q;
        pc_wb_d   = pc_wb_q;
        wb_wren_d = 1'b0;
        commit_d  = 1'b0;
        cnt_d     = cnt_q + 64'(state_q == WB_COMMIT);

        case (state_q)
            WB_IDLE, WB_COMMIT: begin
                if (transfer) begin
                    pc_d   = pc_i;
                    rd_d   = rd_idx_i;
                    wben_d = wben_i;
                    fun3_d = load_fun3_i;
                    alo_d  = addr_lo_i;
                    if (is_load_i) begin
                        state_d = WB_WAIT;
                    end else begin
                        state_d   = WB_COMMIT;
                        commit_d  = 1'b1;
                        wb_wren_d = wben_i & (|rd_idx_i);
                        wb_rdid_d = rd_idx_i;
                        wb_data_d = alu_res_i;
                        pc_wb_d   = pc_i;
                    end
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d   = WB_COMMIT;
                    commit_d  = 1'b1;
                    wb_wren_d = wben_q & (|rd_q);
                    wb_rdid_d = rd_q;
                    wb_data_d = ld_data;
                    pc_wb_d   = pc_q;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WB_IDLE;
            pc_q      <= '0;
            rd_q      <= '0;
            wben_q    <= 1'b0;
            fun3_q    <= '0;
            alo_q     <= '0;
            wb_data_q <= '0;
            wb_rdid_q <= '0;
            wb_wren_q <= 1'b0;
            pc_wb_q   <= '0;
            commit_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            wben_q    <= wben_d;
            fun3_q    <= fun3_d;
            alo_q     <= alo_d;
            wb_data_q <= wb_data_d;
            wb_rdid_q <= wb_rdid_d;
            wb_wren_q <= wb_wren_d;
            pc_wb_q   <= pc_wb_d;
            commit_q  <= commit_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb_data_o    = wb_data_q;
    assign wb_rdid_o    = wb_rdid_q;
    assign wb_wren_o    = wb_wren_q;
    assign pc_wb_o      = pc_wb_q;
    assign commit_o     = commit_q;
    assign commit_cnt_o = cnt_q;

endmodule
